// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle HI/LO multiply/divide sequencer for the execute stage.
// It uses a 2-stage multiplier, an accumulate step and a 32-step restoring divider.
module muldiv_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic        to_gpr_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [63:0] hilo_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [2:0] {
    IDLE,
    MUL1,
    MUL2,
    ACC,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX,
    DONE
  } state_t;

  state_t state;

  logic               isAccQ;
  logic               isSubQ;
  logic               toGprQ;
  logic [63:0]        hiloQ;
  logic signed [49:0] pp0Q;
  logic signed [49:0] pp1Q;
  logic [63:0]        prodQ;
  logic [31:0]        dvdQ;
  logic [31:0]        dvsQ;
  logic [31:0]        remQ;
  logic [4:0]         cnt;
  logic               qNegQ;
  logic               rNegQ;
  logic [31:0]        hiQ;
  logic [31:0]        loQ;
  logic               doneQ;
  logic               weQ;

  logic               isDiv;
  logic               sgnIn;
  logic               divZero;
  logic               negA;
  logic               negB;
  logic [31:0]        absA;
  logic [31:0]        absB;
  logic signed [32:0] aS;
  logic signed [16:0] bLoS;
  logic signed [16:0] bHiS;
  logic signed [49:0] pp0D;
  logic signed [49:0] pp1D;
  logic [63:0]        prodD;
  logic [63:0]        accD;
  logic [32:0]        shifted;
  logic [32:0]        diff;
  logic               geq;
  logic [31:0]        remD;

  // Operand decode and the first multiply stage, taken straight off the inputs
  always_comb begin
    isDiv   = op_i[1] & ~op_i[2] & ~to_gpr_i;
    sgnIn   = ~op_i[0] | to_gpr_i;
    divZero = (b_i == 32'd0);
    negA    = sgnIn & a_i[31];
    negB    = sgnIn & b_i[31];
    absA    = negA ? -a_i : a_i;
    absB    = negB ? -b_i : b_i;
    aS      = {sgnIn & a_i[31], a_i};
    bLoS    = {1'b0, b_i[15:0]};
    bHiS    = {sgnIn & b_i[31], b_i[31:16]};
    pp0D    = 50'(aS) * 50'(bLoS);
    pp1D    = 50'(aS) * 50'(bHiS);
  end

  always_comb begin
    prodD = 64'(pp0Q) + (64'(pp1Q) << 16);
    accD  = isSubQ ? hiloQ - prodQ
                   : hiloQ + prodQ;
  end

  // remQ < dvsQ holds, so a set top bit of shifted always means "fits"
  always_comb begin
    shifted = {remQ, dvdQ[31]};
    diff    = shifted - {1'b0, dvsQ};
    geq     = shifted[32] | ~diff[32];
    remD    = geq ? diff[31:0] : shifted[31:0];
  end

  // MUL1 and DIV_PREP work happens on the accept edge.
  // That way each result lands in DONE on its fixed cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      isAccQ <= 1'b0;
      isSubQ <= 1'b0;
      toGprQ <= 1'b0;
      hiloQ  <= '0;
      pp0Q   <= '0;
      pp1Q   <= '0;
      prodQ  <= '0;
      dvdQ   <= '0;
      dvsQ   <= '0;
      remQ   <= '0;
      cnt    <= '0;
      qNegQ  <= 1'b0;
      rNegQ  <= 1'b0;
      hiQ    <= '0;
      loQ    <= '0;
      doneQ  <= 1'b0;
      weQ    <= 1'b0;
    end else if (flush_i && state != IDLE) begin
      state <= IDLE;
      doneQ <= 1'b0;
      weQ   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            isAccQ <= op_i[2] & ~to_gpr_i;
            isSubQ <= op_i[1];
            toGprQ <= to_gpr_i;
            hiloQ  <= hilo_i;
            if (!isDiv) begin
              pp0Q  <= pp0D;
              pp1Q  <= pp1D;
              state <= MUL2;
            end else if (divZero) begin
              doneQ <= 1'b1;
              weQ   <= 1'b0;
              state <= DONE;
            end else begin
              dvdQ  <= absA;
              dvsQ  <= absB;
              remQ  <= '0;
              cnt   <= 5'd31;
              qNegQ <= negA ^ negB;
              rNegQ <= negA;
              state <= DIV_ITER;
            end
          end
        end
        MUL2: begin
          if (isAccQ) begin
            prodQ <= prodD;
            state <= ACC;
          end else begin
            hiQ   <= prodD[63:32];
            loQ   <= prodD[31:0];
            doneQ <= 1'b1;
            weQ   <= ~toGprQ;
            state <= DONE;
          end
        end
        ACC: begin
          hiQ   <= accD[63:32];
          loQ   <= accD[31:0];
          doneQ <= 1'b1;
          weQ   <= ~toGprQ;
          state <= DONE;
        end
        DIV_ITER: begin
          remQ <= remD;
          dvdQ <= {dvdQ[30:0], geq};
          if (cnt == 5'd0) begin
            state <= DIV_FIX;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV_FIX: begin
          loQ   <= qNegQ ? -dvdQ : dvdQ;
          hiQ   <= rNegQ ? -remQ : remQ;
          doneQ <= 1'b1;
          weQ   <= ~toGprQ;
          state <= DONE;
        end
        DONE: begin
          doneQ <= 1'b0;
          weQ   <= 1'b0;
          state <= IDLE;
        end
        MUL1, DIV_PREP: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall_o = ((state == IDLE) & start_i & ~flush_i)
            | ((state != IDLE) & (state != DONE));
    done_o    = doneQ & ~flush_i;
    hilo_we_o = weQ & ~flush_i;
    hi_o      = hiQ;
    lo_o      = loQ;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
// Cycle 0 is the accept cycle, and outputs are sampled on the falling edge.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic [2:0]  op_i;
  logic        to_gpr_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [63:0] hilo_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int nChecks = 0;
  int nErrors = 0;

  muldiv_seq dut (
    .clk(clk),
    .resetn(resetn),
    .start_i(start_i),
    .op_i(op_i),
    .to_gpr_i(to_gpr_i),
    .a_i(a_i),
    .b_i(b_i),
    .hilo_i(hilo_i),
    .flush_i(flush_i),
    .stall_o(stall_o),
    .done_o(done_o),
    .hilo_we_o(hilo_we_o),
    .hi_o(hi_o),
    .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic gpr,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hilo, input string tag);
    @(negedge clk);
    start_i  = 1'b1;
    op_i     = op;
    to_gpr_i = gpr;
    a_i      = a;
    b_i      = b;
    hilo_i   = hilo;
    #1 checkVal({tag, ".stall0"}, 64'(stall_o), 64'd1);
    @(posedge clk);
    #1 start_i = 1'b0;
    to_gpr_i = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int expCyc,
                          input logic [63:0] expHiLo,
                          input logic expWe);
    int cyc;
    int gap;
    gap = 0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done_o) break;
      if (!stall_o) gap++;
    end
    checkVal({tag, ".cycle"}, 64'(cyc), 64'(expCyc));
    checkVal({tag, ".hilo"}, {hi_o, lo_o}, expHiLo);
    checkVal({tag, ".we"}, 64'(hilo_we_o), 64'(expWe));
    checkVal({tag, ".stallDone"}, 64'(stall_o), 64'd0);
    checkVal({tag, ".stallGap"}, 64'(gap), 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [2:0] op,
                       input logic gpr, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] hilo,
                       input int expCyc, input logic [63:0] expHiLo,
                       input logic expWe);
    issue(op, gpr, a, b, hilo, tag);
    waitDone(tag, expCyc, expHiLo, expWe);
  endtask

  initial begin
    int dones;
    int stalls;
    resetn   = 1'b0;
    start_i  = 1'b0;
    op_i     = 3'd0;
    to_gpr_i = 1'b0;
    a_i      = '0;
    b_i      = '0;
    hilo_i   = '0;
    flush_i  = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rst.done", 64'(done_o), 64'd0);
    checkVal("rst.we", 64'(hilo_we_o), 64'd0);
    checkVal("rst.hilo", {hi_o, lo_o}, 64'd0);
    checkVal("rst.stall", 64'(stall_o), 64'd0);
    resetn = 1'b1;

    runOp("mult", 3'b000, 1'b0, 32'hFFFFFFFF, 32'd2, 64'd0,
          2, 64'hFFFFFFFF_FFFFFFFE, 1'b1);
    runOp("multu", 3'b001, 1'b0, 32'hFFFFFFFF, 32'd2, 64'd0,
          2, 64'h00000001_FFFFFFFE, 1'b1);
    runOp("madd", 3'b100, 1'b0, 32'd3, 32'd4, 64'd5,
          3, 64'h00000000_00000011, 1'b1);
    runOp("msubu", 3'b111, 1'b0, 32'd1, 32'd1, 64'd0,
          3, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
    runOp("msub", 3'b110, 1'b0, 32'hFFFFFFFE, 32'd3, 64'h10,
          3, 64'h00000000_00000016, 1'b1);
    runOp("div", 3'b010, 1'b0, 32'hFFFFFFF9, 32'd2, 64'd0,
          34, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
    runOp("divNegB", 3'b010, 1'b0, 32'd7, 32'hFFFFFFFE, 64'd0,
          34, 64'h00000001_FFFFFFFD, 1'b1);
    runOp("divu", 3'b011, 1'b0, 32'hFFFFFFFF, 32'h10, 64'd0,
          34, 64'h0000000F_0FFFFFFF, 1'b1);
    runOp("div0", 3'b010, 1'b0, 32'd5, 32'd0, 64'd0,
          1, 64'h0000000F_0FFFFFFF, 1'b0);
    runOp("mulGpr", 3'b000, 1'b1, 32'd6, 32'd7, 64'd0,
          2, 64'h00000000_0000002A, 1'b0);

    // Flush mid-divide, then stay quiet through cycle 40
    issue(3'b011, 1'b0, 32'hFFFFFFFF, 32'h10, 64'd0, "fl1");
    stalls = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (stall_o) stalls++;
    end
    checkVal("fl1.busy", 64'(stalls), 64'd9);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    dones  = 0;
    stalls = 0;
    for (int k = 11; k <= 40; k++) begin
      @(negedge clk);
      if (done_o) dones++;
      if (stall_o) stalls++;
    end
    checkVal("fl1.noDone", 64'(dones), 64'd0);
    checkVal("fl1.noStall", 64'(stalls), 64'd0);

    // Flush at cycle 10, then MULT at cycle 12 ends at cycle 14
    issue(3'b011, 1'b0, 32'hFFFFFFFF, 32'h10, 64'd0, "fl2");
    repeat (9) @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    checkVal("fl2.stall11", 64'(stall_o), 64'd0);
    checkVal("fl2.done11", 64'(done_o), 64'd0);
    runOp("fl2.mult", 3'b000, 1'b0, 32'd9, 32'd9, 64'd0,
          2, 64'h00000000_00000051, 1'b1);

    // Flush landing in the DONE cycle masks the result strobe
    issue(3'b000, 1'b0, 32'd3, 32'd5, 64'd0, "flDone");
    @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    checkVal("flDone.done", 64'(done_o), 64'd0);
    checkVal("flDone.we", 64'(hilo_we_o), 64'd0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    checkVal("flDone.after", 64'(done_o), 64'd0);

    // Reset in the middle of a divide
    runOp("pre", 3'b000, 1'b0, 32'hFFFFFFFF, 32'd2, 64'd0,
          2, 64'hFFFFFFFF_FFFFFFFE, 1'b1);
    issue(3'b010, 1'b0, 32'd100, 32'd7, 64'd0, "rstMid");
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    checkVal("rstMid.done", 64'(done_o), 64'd0);
    checkVal("rstMid.we", 64'(hilo_we_o), 64'd0);
    checkVal("rstMid.hilo", {hi_o, lo_o}, 64'd0);
    checkVal("rstMid.stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 3'b000;
    a_i     = 32'd2;
    b_i     = 32'd2;
    #1 checkVal("sf.stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1 start_i = 1'b0;
    flush_i = 1'b0;
    dones  = 0;
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_o) dones++;
      if (stall_o) stalls++;
    end
    checkVal("sf.noDone", 64'(dones), 64'd0);
    checkVal("sf.noStall", 64'(stalls), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
